// File: rtl/pwl_act_pipe.sv
// pwl_act_pipe: 3-stage, LANES-wide 16-segment piecewise-linear activation
// (sigmoid / tanh / ReLU / custom table) with valid/ready on both sides.
module pwl_act_pipe #(
  parameter int LANES = 64,
  parameter int DW    = 8,
  parameter int OW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANES*DW-1:0] s_data,
  input  logic [1:0]          s_mode,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LANES*OW-1:0] m_data,
  output logic [1:0]          m_mode,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_addr,
  input  logic [OW-1:0]       cfg_data
);
  localparam int LW = DW - 4;   // segment-local offset width
  localparam int SH = DW - 3;
  localparam int PW = OW + LW;
  localparam logic signed [OW+1:0] T_MAX = (OW+2)'(2**(OW-1) - 1);
  localparam logic signed [OW+1:0] T_MIN = ~T_MAX;
  localparam logic signed [OW+1:0] HALF  = (OW+2)'(2**(OW-1));

  typedef enum logic [1:0] {
    MODE_SIG  = 2'd0,
    MODE_TANH = 2'd1,
    MODE_RELU = 2'd2,
    MODE_CUST = 2'd3
  } mode_e;

  function automatic logic [7:0] sig_off(input logic [3:0] seg);
    case (seg)
      4'h0: sig_off = 8'h80;  4'h1: sig_off = 8'h9F;
      4'h2: sig_off = 8'hBB;  4'h3: sig_off = 8'hD1;
      4'h4: sig_off = 8'hE1;  4'h5: sig_off = 8'hEC;
      4'h6: sig_off = 8'hF3;  4'h7: sig_off = 8'hF8;
      4'h8: sig_off = 8'h04;  4'h9: sig_off = 8'h07;
      4'hA: sig_off = 8'h0C;  4'hB: sig_off = 8'h13;
      4'hC: sig_off = 8'h1E;  4'hD: sig_off = 8'h2E;
      4'hE: sig_off = 8'h44;  default: sig_off = 8'h60;
    endcase
  endfunction

  // Sigmoid slopes are mirror-symmetric about x=0, so 8 values cover 16 segments.
  function automatic logic [7:0] sig_slope(input logic [3:0] seg);
    logic [2:0] k;
    k = seg[3] ? ~seg[2:0] : seg[2:0];
    case (k)
      3'd0: sig_slope = 8'h3E;  3'd1: sig_slope = 8'h37;
      3'd2: sig_slope = 8'h2C;  3'd3: sig_slope = 8'h20;
      3'd4: sig_slope = 8'h16;  3'd5: sig_slope = 8'h0E;
      3'd6: sig_slope = 8'h09;  default: sig_slope = 8'h05;
    endcase
  endfunction

  function automatic logic [DW-1:0] dbl_sat(input logic [DW-1:0] x);
    if (x[DW-1] != x[DW-2])
      dbl_sat = x[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      dbl_sat = {x[DW-2:0], 1'b0};
  endfunction

  function automatic logic [OW-1:0] lane_out(input mode_e mode, input logic [DW-1:0] x,
                                              input logic [OW-1:0] off, input logic [PW-1:0] prod);
    logic [OW:0]          sum;
    logic [OW-1:0]        ys;
    logic [OW-1:0]        relu;
    logic signed [OW+1:0] t;
    sum = {1'b0, OW'(prod >> SH)} + {1'b0, off};
    ys  = sum[OW] ? '1 : sum[OW-1:0];
    t   = (signed'({2'b00, ys}) - HALF) <<< 1;
    if (t > T_MAX)      t = T_MAX;
    else if (t < T_MIN) t = T_MIN;
    if (x[DW-1])                       relu = '0;
    else if (int'(x) > 2**(OW-1) - 1)  relu = OW'(2**(OW-1) - 1);
    else                               relu = OW'(x);
    case (mode)
      MODE_TANH: lane_out = t[OW-1:0];
      MODE_RELU: lane_out = relu;
      default:   lane_out = ys;
    endcase
  endfunction

  // Custom coefficient table
  logic [OW-1:0] cust_off   [16];
  logic [OW-1:0] cust_slope [16];

  // NOTE: this table is a small flop array, so it is reset to the sigmoid defaults like any register; a RAM could not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        cust_off[i]   <= OW'(sig_off(4'(i)));
        cust_slope[i] <= OW'(sig_slope(4'(i)));
      end
    end else if (cfg_we) begin
      if (cfg_addr[4]) cust_slope[cfg_addr[3:0]] <= cfg_data;
      else             cust_off[cfg_addr[3:0]]   <= cfg_data;
    end
  end

  logic  en;
  mode_e s_mode_e;
  assign en       = ~m_valid | m_ready;
  assign s_ready  = en & ~rst;
  assign s_mode_e = mode_e'(s_mode);

  // Tanh reuses the sigmoid datapath on the doubled input.
  logic [DW-1:0] xe_d    [LANES];
  logic [OW-1:0] off_d   [LANES];
  logic [OW-1:0] slope_d [LANES];
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      xe_d[i]    = (s_mode_e == MODE_TANH) ? dbl_sat(s_data[DW*i +: DW]) : s_data[DW*i +: DW];
      off_d[i]   = (s_mode_e == MODE_CUST) ? cust_off[xe_d[i][DW-1 -: 4]]
                                           : OW'(sig_off(xe_d[i][DW-1 -: 4]));
      slope_d[i] = (s_mode_e == MODE_CUST) ? cust_slope[xe_d[i][DW-1 -: 4]]
                                           : OW'(sig_slope(xe_d[i][DW-1 -: 4]));
    end
  end

  logic          v1, v2;
  mode_e         s1_mode, s2_mode;
  logic [DW-1:0] s1_x     [LANES];
  logic [DW-1:0] s2_x     [LANES];
  logic [OW-1:0] s1_off   [LANES];
  logic [OW-1:0] s1_slope [LANES];
  logic [OW-1:0] s2_off   [LANES];
  logic [PW-1:0] s2_prod  [LANES];

  // NOTE: datapath stages carry no reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_mode <= s_mode_e;
      s2_mode <= s1_mode;
      for (int i = 0; i < LANES; i++) begin
        s1_x[i]     <= xe_d[i];
        s1_off[i]   <= off_d[i];
        s1_slope[i] <= slope_d[i];
        s2_x[i]     <= s1_x[i];
        s2_off[i]   <= s1_off[i];
        s2_prod[i]  <= PW'(s1_slope[i]) * PW'(s1_x[i][LW-1:0]);
      end
    end
  end

  logic [LANES*OW-1:0] y_d;
  always_comb begin
    y_d = '0;
    for (int i = 0; i < LANES; i++)
      y_d[OW*i +: OW] = lane_out(s2_mode, s2_x[i], s2_off[i], s2_prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_mode  <= '0;
    end else if (en) begin
      v1      <= s_valid;
      v2      <= v1;
      m_valid <= v2;
      m_data  <= y_d;
      m_mode  <= s2_mode;
    end
  end
endmodule
